// File: rtl/drop_ctrl_pkg.sv
// Shared types and defaults for the bag drop controller.
// Holds the FSM state encoding, status display codes and default widths.
package drop_ctrl_pkg;

    localparam int HEIGHT_W_DEF      = 8;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int TOL_DEF           = 1;
    localparam int DROP_CYCLES_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        DROP,
        HOLD
    } state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MEAS = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;
    localparam logic [1:0] ST_HIGH = 2'b11;

endpackage

// File: rtl/height_stability_filter.sv
// Purpose: tracks a reference height and counts consecutive in-tolerance valid samples.
// Latency: stable is a decode of the registered count, so it rises one edge after the last qualifying sample.
// Backpressure: none; invalid cycles freeze the reference and the count.
module height_stability_filter #(
    parameter int HEIGHT_W      = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int TOL           = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                track,
    input  logic [HEIGHT_W-1:0] height,
    input  logic                height_valid,
    output logic                stable,
    output logic [HEIGHT_W-1:0] ref_height
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [HEIGHT_W:0] TOL_V = (HEIGHT_W + 1)'(TOL);

    logic [CNT_W-1:0]  cnt;
    logic [HEIGHT_W:0] diff;
    logic              in_tol;

    // Difference is one bit wider than the inputs so it never wraps.
    always_comb begin
        diff = '0;
        if (height >= ref_height)
            diff = {1'b0, height} - {1'b0, ref_height};
        else
            diff = {1'b0, ref_height} - {1'b0, height};
        in_tol = (diff <= TOL_V);
        stable = (cnt == CNT_W'(STABLE_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_height <= '0;
            cnt        <= '0;
        end else if (load) begin
            ref_height <= height;
            cnt        <= CNT_W'(1);
        end else if (track && height_valid && !stable) begin
            if (in_tol) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                ref_height <= height;
                cnt        <= CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/drop_controller.sv
// Purpose: waits for a stable bag height, compares it with max_height, then fires a drop pulse or flags too-high.
// Latency: with a valid stable input every cycle, drop_activated rises STABLE_CYCLES+1 edges after the request sample.
// Backpressure: none; the outcome is held until drop_en drops. Optional drop_count port via DROP_CTRL_COUNT_EN.
module drop_controller
    import drop_ctrl_pkg::*;
#(
    parameter int HEIGHT_W      = HEIGHT_W_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int TOL           = TOL_DEF,
    parameter int DROP_CYCLES   = DROP_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HEIGHT_W-1:0] height,
    input  logic                height_valid,
    input  logic [HEIGHT_W-1:0] max_height,
    input  logic                drop_en,
    output logic                drop_activated,
    output logic [1:0]          status,
    output logic [HEIGHT_W-1:0] stable_height,
    output logic                busy
`ifdef DROP_CTRL_COUNT_EN
    ,
    output logic [15:0]         drop_count
`endif
);

    localparam int TMR_W = $clog2(DROP_CYCLES + 1);

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               start;
    logic               abort;
    logic               accept;
    logic               stable;
    logic [HEIGHT_W-1:0] ref_height;

    assign start  = (state == IDLE) && drop_en && height_valid && (height != '0);
    assign abort  = !drop_en || (height_valid && (height == '0));
    assign accept = (state == CHECK) && (ref_height <= max_height);

    height_stability_filter #(
        .HEIGHT_W      (HEIGHT_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TOL           (TOL)
    ) u_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (start),
        .track        (state == SETTLE),
        .height       (height),
        .height_valid (height_valid),
        .stable       (stable),
        .ref_height   (ref_height)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            drop_activated <= 1'b0;
            status         <= ST_IDLE;
            stable_height  <= '0;
            busy           <= 1'b0;
            timer          <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= SETTLE;
                    status <= ST_MEAS;
                    busy   <= 1'b1;
                end
                // Aborts win over a completing stability count.
                SETTLE: if (abort) begin
                    state  <= IDLE;
                    status <= ST_IDLE;
                    busy   <= 1'b0;
                end else if (stable) begin
                    state         <= CHECK;
                    stable_height <= ref_height;
                end
                CHECK: if (accept) begin
                    state          <= DROP;
                    status         <= ST_DROP;
                    drop_activated <= 1'b1;
                    timer          <= '0;
                end else begin
                    state  <= HOLD;
                    status <= ST_HIGH;
                end
                DROP: if (timer == TMR_W'(DROP_CYCLES - 1)) begin
                    state          <= HOLD;
                    drop_activated <= 1'b0;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
                HOLD: if (!drop_en) begin
                    state  <= IDLE;
                    status <= ST_IDLE;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DROP_CTRL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else if (accept && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller: expected per-cycle outputs are queued as stimulus is driven.
module tb_drop_controller;
    import drop_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] height;
    logic       height_valid;
    logic [7:0] max_height;
    logic       drop_en;
    logic       drop_activated;
    logic [1:0] status;
    logic [7:0] stable_height;
    logic       busy;
`ifdef DROP_CTRL_COUNT_EN
    logic [15:0] drop_count;
`endif

    typedef struct packed {
        logic [1:0] status;
        logic       drop;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    always #5 clk = ~clk;

    drop_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .height         (height),
        .height_valid   (height_valid),
        .max_height     (max_height),
        .drop_en        (drop_en),
        .drop_activated (drop_activated),
        .status         (status),
        .stable_height  (stable_height),
        .busy           (busy)
`ifdef DROP_CTRL_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, expv);
        end
    endtask

    task automatic step(input logic en, input logic [7:0] h, input logic v,
                        input logic [1:0] st, input logic dr, input logic bz);
        exp_t e;
        drop_en      = en;
        height       = h;
        height_valid = v;
        e.status = st;
        e.drop   = dr;
        e.busy   = bz;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("status", 32'(status), 32'(e.status));
        check("drop", 32'(drop_activated), 32'(e.drop));
        check("busy", 32'(busy), 32'(e.busy));
    endtask

    task automatic meas(input logic [7:0] h, input logic v);
        step(1'b1, h, v, ST_MEAS, 1'b0, 1'b1);
    endtask

    // From the CHECK->DROP edge: 16-cycle pulse, HOLD, then release.
    task automatic accept_tail(input logic [7:0] h);
        for (int i = 0; i < 16; i++) step(1'b1, h, 1'b1, ST_DROP, 1'b1, 1'b1);
        step(1'b1, h, 1'b1, ST_DROP, 1'b0, 1'b1);
        step(1'b1, h, 1'b1, ST_DROP, 1'b0, 1'b1);
        step(1'b0, h, 1'b1, ST_IDLE, 1'b0, 1'b0);
        check("stable_height", 32'(stable_height), 32'(h));
    endtask

    task automatic bag(input logic [7:0] h, input bit ok);
        for (int i = 0; i < 5; i++) meas(h, 1'b1);
        check("stable_at_check", 32'(stable_height), 32'(h));
        if (ok) begin
            accept_tail(h);
        end else begin
            for (int i = 0; i < 3; i++) step(1'b1, h, 1'b1, ST_HIGH, 1'b0, 1'b1);
            step(1'b0, h, 1'b1, ST_IDLE, 1'b0, 1'b0);
            check("stable_height", 32'(stable_height), 32'(h));
        end
    endtask

    initial begin
        drop_en      = 1'b0;
        height       = 8'd0;
        height_valid = 1'b0;
        max_height   = 8'd100;

        phase = "reset";
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drop_en      = 1'($urandom);
            height       = 8'($urandom);
            height_valid = 1'($urandom);
            @(posedge clk);
            #1;
            check("drop", 32'(drop_activated), 32'd0);
            check("status", 32'(status), 32'd0);
            check("stable_height", 32'(stable_height), 32'd0);
            check("busy", 32'(busy), 32'd0);
        end
        drop_en      = 1'b0;
        height_valid = 1'b0;
        rst_n        = 1'b1;
        step(1'b0, 8'd0, 1'b0, ST_IDLE, 1'b0, 1'b0);

        phase = "accept";
        bag(8'd80, 1'b1);

        phase = "reject";
        bag(8'd101, 1'b0);

        phase = "jitter";
        meas(8'd80, 1'b1);
        meas(8'd81, 1'b1);
        meas(8'd80, 1'b1);
        meas(8'd83, 1'b1);
        meas(8'd83, 1'b1);
        meas(8'd84, 1'b1);
        meas(8'd83, 1'b1);
        meas(8'd83, 1'b1);
        accept_tail(8'd83);

        phase = "abort";
        meas(8'd50, 1'b1);
        meas(8'd50, 1'b1);
        step(1'b0, 8'd50, 1'b1, ST_IDLE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd50, 1'b1, ST_IDLE, 1'b0, 1'b0);

        phase = "abort_at_complete";
        for (int i = 0; i < 4; i++) meas(8'd50, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd50, 1'b1, ST_IDLE, 1'b0, 1'b0);

        phase = "equal_max";
        bag(8'd100, 1'b1);

        phase = "zero";
        meas(8'd60, 1'b1);
        meas(8'd60, 1'b1);
        step(1'b1, 8'd0, 1'b1, ST_IDLE, 1'b0, 1'b0);
        step(1'b1, 8'd0, 1'b1, ST_IDLE, 1'b0, 1'b0);

        phase = "invalid_gap";
        meas(8'd60, 1'b1);
        meas(8'd60, 1'b1);
        meas(8'd0, 1'b0);
        meas(8'd0, 1'b0);
        for (int i = 0; i < 3; i++) meas(8'd60, 1'b1);
        accept_tail(8'd60);

        phase = "reset_mid_drop";
        for (int i = 0; i < 5; i++) meas(8'd80, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'd80, 1'b1, ST_DROP, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("drop_async", 32'(drop_activated), 32'd0);
        check("status_async", 32'(status), 32'd0);
        check("busy_async", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 8'd80, 1'b0, ST_IDLE, 1'b0, 1'b0);
`ifdef DROP_CTRL_COUNT_EN
        check("count_after_reset", 32'(drop_count), 32'd0);
        phase = "count";
        bag(8'd70, 1'b1);
        bag(8'd90, 1'b1);
        check("count_two", 32'(drop_count), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
